// File: rtl/data_lsu_if.sv
// data_lsu_if: request/response bus between the datapath and the LSU,
// plus the word-addressed data-memory port the LSU drives.
interface data_lsu_if;
    logic        req;
    logic        we;
    logic [2:0]  dt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;
    logic        fault;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req, we, dt, addr, wdata, mem_rd,
        output rdata, done, busy, fault, mem_addr, mem_we, mem_wd
    );

    modport master (
        output req, we, dt, addr, wdata, mem_rd,
        input  rdata, done, busy, fault, mem_addr, mem_we, mem_wd
    );
endinterface

// File: rtl/data_lsu.sv
// data_lsu: byte/half/word load-store unit in front of a word-addressed
// memory without byte enables. Sub-word stores are read-modify-write.
// Optional LSU_MISALIGNED_EN: misaligned accesses proceed, word-spanning
// ones use a second read/capture/write on the next word address.
module data_lsu (
    input  logic      clk,
    input  logic      rst,
    data_lsu_if.slave bus
);
    localparam int unsigned DW = 32;

    typedef enum logic [2:0] {IDLE, RD, CAP, RD2, CAP2, WR, WR2, DONE} state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      dt_q, dt_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   word0_q, word0_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   maddr_q, maddr_d;
    logic            mwe_q, mwe_d;
    logic [DW-1:0]   mwd_q, mwd_d;
    logic            illegal_c, reject_c, split_req_c;
`ifdef LSU_MISALIGNED_EN
    logic            split_q, split_d;
    logic [DW-1:0]   word1_q, word1_d;
    logic [2:0]      req_sz_c;
`else
    logic            misaligned_c;
`endif

    function automatic logic [2:0] size_of(input logic [1:0] code);
        case (code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Replace the access bytes falling in word `hi` of the two-word window.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  off,
                                               input logic [2:0]  sz,
                                               input logic        hi);
        logic [31:0] res;
        logic [2:0]  pos, rel;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            pos = {hi, 2'(i)};
            rel = pos - {1'b0, off};
            if ((pos >= {1'b0, off}) && (rel < sz))
                res[i*8 +: 8] = wd[{rel[1:0], 3'b000} +: 8];
        end
        return res;
    endfunction

    // Pick bytes [off .. off+size-1] of {hi, lo} and extend per funct3.
    function automatic logic [31:0] extract(input logic [31:0] lo,
                                            input logic [31:0] hi,
                                            input logic [1:0]  off,
                                            input logic [2:0]  dt);
        logic [63:0] pair;
        logic [5:0]  base;
        logic [7:0]  b0, b1, b2, b3;
        pair = {hi, lo};
        base = {1'b0, off, 3'b000};
        b0 = pair[base +: 8];
        b1 = pair[base + 6'd8 +: 8];
        b2 = pair[base + 6'd16 +: 8];
        b3 = pair[base + 6'd24 +: 8];
        case (dt)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b010:  return {b3, b2, b1, b0};
            3'b100:  return {24'h0, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    // Request classification from the live request inputs
    assign illegal_c = (bus.dt == 3'b011) || (bus.dt == 3'b110) ||
                       (bus.dt == 3'b111) || (bus.we && bus.dt[2]);
`ifdef LSU_MISALIGNED_EN
    assign req_sz_c    = size_of(bus.dt[1:0]);
    assign split_req_c = (3'({1'b0, bus.addr[1:0]}) + req_sz_c) > 3'd4;
    assign reject_c    = illegal_c;
`else
    assign misaligned_c = ((bus.dt[1:0] == 2'b01) && bus.addr[0]) ||
                          ((bus.dt[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    assign reject_c     = illegal_c || misaligned_c;
    assign split_req_c  = 1'b0;
`endif

    // Next state, latched request/data and next values of registered outputs
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        dt_d    = dt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word0_d = word0_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGNED_EN
        split_d = split_q;
        word1_d = word1_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    dt_d    = bus.dt;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    word0_d = bus.wdata;
`ifdef LSU_MISALIGNED_EN
                    split_d = split_req_c;
`endif
                    if (reject_c)
                        state_d = DONE;
                    else if (bus.we && (bus.dt[1:0] == 2'b10) && !split_req_c)
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                word0_d = we_q ? merge_word(bus.mem_rd, wdata_q, addr_q[1:0],
                                            size_of(dt_q[1:0]), 1'b0)
                               : bus.mem_rd;
`ifdef LSU_MISALIGNED_EN
                if (split_q)
                    state_d = RD2;
                else
`endif
                if (we_q)
                    state_d = WR;
                else begin
                    rdata_d = extract(bus.mem_rd, 32'h0, addr_q[1:0], dt_q);
                    state_d = DONE;
                end
            end
`ifdef LSU_MISALIGNED_EN
            RD2: state_d = CAP2;
            CAP2: begin
                if (we_q) begin
                    word1_d = merge_word(bus.mem_rd, wdata_q, addr_q[1:0],
                                         size_of(dt_q[1:0]), 1'b1);
                    state_d = WR;
                end else begin
                    rdata_d = extract(word0_q, bus.mem_rd, addr_q[1:0], dt_q);
                    state_d = DONE;
                end
            end
            WR:  state_d = split_q ? WR2 : DONE;
            WR2: state_d = DONE;
`else
            WR:  state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        fault_d = (state_q == IDLE) && (state_d == DONE);
        maddr_d = '0;
        mwe_d   = 1'b0;
        mwd_d   = '0;
        case (state_d)
            RD, CAP: maddr_d = {addr_d[31:2], 2'b00};
            WR: begin
                maddr_d = {addr_d[31:2], 2'b00};
                mwe_d   = 1'b1;
                mwd_d   = word0_d;
            end
`ifdef LSU_MISALIGNED_EN
            RD2, CAP2: maddr_d = {addr_d[31:2] + 30'd1, 2'b00};
            WR2: begin
                maddr_d = {addr_d[31:2] + 30'd1, 2'b00};
                mwe_d   = 1'b1;
                mwd_d   = word1_d;
            end
`endif
            default: ;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            dt_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
            maddr_q <= '0;
            mwe_q   <= 1'b0;
            mwd_q   <= '0;
`ifdef LSU_MISALIGNED_EN
            split_q <= 1'b0;
            word1_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            dt_q    <= dt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word0_q <= word0_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            busy_q  <= busy_d;
            maddr_q <= maddr_d;
            mwe_q   <= mwe_d;
            mwd_q   <= mwd_d;
`ifdef LSU_MISALIGNED_EN
            split_q <= split_d;
            word1_q <= word1_d;
`endif
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.done     = done_q;
    assign bus.fault    = fault_q;
    assign bus.busy     = busy_q;
    assign bus.mem_addr = maddr_q;
    assign bus.mem_we   = mwe_q;
    assign bus.mem_wd   = mwd_q;
endmodule

// File: tb/tb_data_lsu.sv
// tb_data_lsu: directed and random accesses against a byte-level memory
// model; expected latency, fault, write count and data come from the model.
module tb_data_lsu;
`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    data_lsu_if ifc();

    data_lsu dut (.clk(clk), .rst(rst), .bus(ifc));

    logic [31:0] dmem [64];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;
    logic [7:0]  ref_bytes [256];
    logic [31:0] ref_rdata;
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data memory with a backdoor preload port
    always @(posedge clk) begin
        if (bd_we)
            dmem[bd_idx] <= bd_data;
        else if (ifc.mem_we)
            dmem[ifc.mem_addr[7:2]] <= ifc.mem_wd;
        ifc.mem_rd <= dmem[ifc.mem_addr[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        for (int k = 0; k < 4; k++) ref_bytes[{idx, 2'(k)}] = data[k*8 +: 8];
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    function automatic logic [31:0] ref_word(input logic [5:0] idx);
        return {ref_bytes[{idx, 2'd3}], ref_bytes[{idx, 2'd2}],
                ref_bytes[{idx, 2'd1}], ref_bytes[{idx, 2'd0}]};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdata"}, ifc.rdata, 32'h0);
        check({tag, "_done"}, 32'(ifc.done), 32'h0);
        check({tag, "_busy"}, 32'(ifc.busy), 32'h0);
        check({tag, "_fault"}, 32'(ifc.fault), 32'h0);
        check({tag, "_maddr"}, ifc.mem_addr, 32'h0);
        check({tag, "_mwe"}, 32'(ifc.mem_we), 32'h0);
        check({tag, "_mwd"}, ifc.mem_wd, 32'h0);
    endtask

    // One access: drive, wait for done (bounded), then compare to the model
    task automatic run_op(input logic w, input logic [2:0] d, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold);
        int sz, lat, exp_we, cyc, we_cnt;
        bit illegal, misal, span, exp_fault, got, got_fault;
        logic [31:0] v;
        logic [5:0]  w0;
        sz        = (d[1:0] == 2'b00) ? 1 : (d[1:0] == 2'b01) ? 2 : 4;
        illegal   = (d == 3'b011) || (d == 3'b110) || (d == 3'b111) || (w && d[2]);
        misal     = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        span      = (int'(a[1:0]) + sz) > 4;
        exp_fault = illegal || (misal && !MIS_EN);
        if (exp_fault) begin
            lat = 1; exp_we = 0;
        end else if (w) begin
            exp_we = span ? 2 : 1;
            lat    = span ? 7 : ((sz == 4) ? 2 : 4);
        end else begin
            exp_we = 0;
            lat    = span ? 5 : 3;
        end

        ifc.req = 1'b1; ifc.we = w; ifc.dt = d; ifc.addr = a; ifc.wdata = wd;
        @(posedge clk); #1;
        if (!hold) ifc.req = 1'b0;
        ifc.we = ~w; ifc.dt = 3'($urandom); ifc.addr = $urandom; ifc.wdata = $urandom;
        cyc = 0; we_cnt = 0; got = 0; got_fault = 0;
        while (!got && cyc < 20) begin
            cyc++;
            if (ifc.mem_we) we_cnt++;
            if (ifc.done) begin
                got = 1;
                got_fault = ifc.fault;
            end else begin
                @(posedge clk); #1;
            end
        end
        ifc.req = 1'b0;
        check("done_seen", 32'(got), 32'h1);
        check("latency", 32'(cyc), 32'(lat));
        check("fault", 32'(got_fault), 32'(exp_fault));
        check("mem_we_pulses", 32'(we_cnt), 32'(exp_we));

        if (!exp_fault) begin
            if (w) begin
                for (int k = 0; k < sz; k++) ref_bytes[8'(a + 32'(k))] = wd[k*8 +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < sz; k++) v[k*8 +: 8] = ref_bytes[8'(a + 32'(k))];
                if (d == 3'b000) v = {{24{v[7]}}, v[7:0]};
                if (d == 3'b001) v = {{16{v[15]}}, v[15:0]};
                ref_rdata = v;
            end
        end

        @(posedge clk); #1;
        check("post_done", 32'(ifc.done), 32'h0);
        check("post_busy", 32'(ifc.busy), 32'h0);
        check("idle_maddr", ifc.mem_addr, 32'h0);
        check("rdata", ifc.rdata, ref_rdata);
        w0 = a[7:2];
        check("mem_w0", dmem[w0], ref_word(w0));
        check("mem_w1", dmem[w0 + 6'd1], ref_word(w0 + 6'd1));
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
        ifc.req = 1'b0; ifc.we = 1'b0; ifc.dt = '0; ifc.addr = '0; ifc.wdata = '0;
        ref_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
        poke(6'd16, 32'hdeadc0de);
        poke(6'd17, 32'hc001beef);

        run_op(1'b0, 3'b001, 32'h42, 32'h0, 1'b0);
        check("lh_42", ifc.rdata, 32'hffffdead);
        run_op(1'b0, 3'b100, 32'h41, 32'h0, 1'b0);
        check("lbu_41", ifc.rdata, 32'h000000c0);
        run_op(1'b0, 3'b000, 32'h43, 32'h0, 1'b0);
        check("lb_43", ifc.rdata, 32'hffffffde);
        run_op(1'b0, 3'b101, 32'h40, 32'h0, 1'b0);
        check("lhu_40", ifc.rdata, 32'h0000c0de);

        poke(6'd16, 32'hdeadbeef);
        run_op(1'b1, 3'b000, 32'h41, 32'h123456aa, 1'b0);
        check("sb_41_mem", dmem[16], 32'hdeadaaef);
        run_op(1'b1, 3'b010, 32'h44, 32'hc001c0de, 1'b0);
        check("sw_44_mem", dmem[17], 32'hc001c0de);

        poke(6'd16, 32'hdeadc0de);
        poke(6'd17, 32'hc001beef);
        run_op(1'b0, 3'b010, 32'h42, 32'h0, 1'b0);
`ifdef LSU_MISALIGNED_EN
        check("lw_42_split", ifc.rdata, 32'hbeefdead);
`else
        check("lw_42_held", ifc.rdata, 32'h0000c0de);
`endif

        run_op(1'b0, 3'b011, 32'h40, 32'h0, 1'b0);
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
        @(posedge clk); #1;
        check("held_req_single_done", 32'(ifc.done), 32'h0);

        // Reset while in CAP
        ifc.req = 1'b1; ifc.we = 1'b0; ifc.dt = 3'b010; ifc.addr = 32'h40;
        @(posedge clk); #1;
        ifc.req = 1'b0;
        @(posedge clk); #1;
        check("cap_busy", 32'(ifc.busy), 32'h1);
        check("cap_maddr", ifc.mem_addr, 32'h40);
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("midrst");
        rst = 1'b0;
        ref_rdata = 32'h0;
        run_op(1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
        check("lw_40_after_rst", ifc.rdata, 32'hdeadc0de);

        for (int i = 0; i < 200; i++) begin
            ra = {(($urandom % 4) == 0) ? 24'hffffff : 24'h000000, 8'($urandom)};
            run_op(1'($urandom), 3'($urandom), ra, $urandom, (($urandom % 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
